// File: rtl/jk_cmd_driver_if.sv
// Target-bit stream into jk_cmd_driver: valid/ready handshake carrying one requested FSM output bit.
// Latency: none, wires only.
// Backpressure: the source holds tgt_valid/tgt_bit until it sees tgt_ready high at a clock edge.
interface jk_cmd_driver_if;
  logic tgt_valid;
  logic tgt_bit;
  logic tgt_ready;

  modport master (
    output tgt_valid,
    output tgt_bit,
    input  tgt_ready
  );

  modport slave (
    input  tgt_valid,
    input  tgt_bit,
    output tgt_ready
  );
endinterface

// File: rtl/jk_cmd_driver.sv
// Purpose: buffers target bits, encodes each into a one-cycle j/k command for a 2-state JK FSM and counts read-back mismatches.
// Latency: push at edge N into an empty FIFO -> j/k in cycle N+1..N+2 -> mismatch pulse in cycle N+3..N+4; one bit per 2 cycles.
// Backpressure: tgt_ready = !full. Build option JK_TOGGLE_EN encodes every state change as j=k=1 (toggle).
module jk_cmd_driver #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  jk_cmd_driver_if.slave   tgt,
  output logic             j,
  output logic             k,
  input  logic             fsm_out,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
  localparam logic [CNT_W-1:0] ERR_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             m_q, m_d;
  logic             cur_tgt_q, cur_tgt_d;
  logic             j_q, j_d;
  logic             k_q, k_d;
  logic             mismatch_q, mismatch_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic head;

  // Command for moving the FSM from its current state m to target t; hold is always j=k=0.
  function automatic logic [1:0] encode(input logic m, input logic t);
    logic [1:0] cmd;
    cmd = 2'b00;
    if (t != m) begin
`ifdef JK_TOGGLE_EN
      cmd = 2'b11;
`else
      cmd = t ? 2'b10 : 2'b01;
`endif
    end
    return cmd;
  endfunction

  assign full          = (count_q == FULL_CNT);
  assign empty         = (count_q == '0);
  assign head          = mem_q[rd_ptr_q];
  assign push          = tgt.tgt_valid && !full;
  assign tgt.tgt_ready = !full;

  assign j        = j_q;
  assign k        = k_q;
  assign mismatch = mismatch_q;
  assign err_cnt  = err_cnt_q;
  assign busy     = !empty || (state_q != IDLE);

  // Sequencer: pop/encode in IDLE or CHECK, clear command after DRIVE, compare read-back in CHECK.
  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    cur_tgt_d  = cur_tgt_q;
    j_d        = 1'b0;
    k_d        = 1'b0;
    mismatch_d = 1'b0;
    err_cnt_d  = err_cnt_q;
    pop        = 1'b0;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          cur_tgt_d  = head;
          {j_d, k_d} = encode(m_q, head);
          state_d    = DRIVE;
        end
      end

      DRIVE: begin
        // The FSM samples the command at this closing edge, so our model of it advances now.
        m_d     = cur_tgt_q;
        state_d = CHECK;
      end

      CHECK: begin
        if (fsm_out != cur_tgt_q) begin
          mismatch_d = 1'b1;
          if (err_cnt_q != ERR_MAX) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
        end
        if (!empty) begin
          pop        = 1'b1;
          cur_tgt_d  = head;
          {j_d, k_d} = encode(m_q, head);
          state_d    = DRIVE;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FIFO bookkeeping: write at wr_ptr on push, advance rd_ptr on pop, occupancy tracks both.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      mem_d[wr_ptr_q] = tgt.tgt_bit;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // State registers; synchronous reset drops queued and in-flight bits without a mismatch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      m_q        <= 1'b0;
      cur_tgt_q  <= 1'b0;
      j_q        <= 1'b0;
      k_q        <= 1'b0;
      mismatch_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      m_q        <= m_d;
      cur_tgt_q  <= cur_tgt_d;
      j_q        <= j_d;
      k_q        <= k_d;
      mismatch_q <= mismatch_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_jk_cmd_driver.sv
// Bench for jk_cmd_driver: a JK FSM (set/clear/toggle, optionally stuck at OFF) is driven by the DUT.
// A queue-based reference predicts every output each cycle; directed steps cover the main scenarios.
// Build with JK_TOGGLE_EN to exercise the toggle encoding.
module tb_jk_cmd_driver;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             j, k, fsm_out, mismatch, busy;
  logic [CNT_W-1:0] err_cnt;

  jk_cmd_driver_if tgt_if();

  jk_cmd_driver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .tgt      (tgt_if.slave),
    .j        (j),
    .k        (k),
    .fsm_out  (fsm_out),
    .mismatch (mismatch),
    .err_cnt  (err_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Driven JK FSM: j sets, k clears, both toggles; 'stuck' forces its output OFF.
  logic fsm_q;
  bit   stuck;
  always @(posedge clk) begin
    if (reset) fsm_q <= 1'b0;
    else begin
      case ({j, k})
        2'b10:   fsm_q <= 1'b1;
        2'b01:   fsm_q <= 1'b0;
        2'b11:   fsm_q <= ~fsm_q;
        default: fsm_q <= fsm_q;
      endcase
    end
  end
  assign fsm_out = stuck ? 1'b0 : fsm_q;

  // Reference: pending bits, the bit in flight and how far it is (1 = command out, 2 = read-back).
  bit mq[$];
  int stage;
  bit cur, m_ref, j_e, k_e, mm_e, pushed;
  int err_e;
  int checks = 0;
  int errors = 0;
  bit s_v, s_b, s_f, s_r;

  function automatic bit [1:0] cmd_for(input bit m, input bit t);
    if (t == m) return 2'b00;
`ifdef JK_TOGGLE_EN
    return 2'b11;
`else
    return t ? 2'b10 : 2'b01;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=completion", tag);
  endtask

  task automatic model_step();
    int sz;
    if (s_r) begin
      mq.delete();
      stage = 0; cur = 0; m_ref = 0; j_e = 0; k_e = 0; mm_e = 0; err_e = 0; pushed = 0;
      return;
    end
    sz     = mq.size();
    pushed = s_v && (sz < DEPTH);
    mm_e   = (stage == 2) && (s_f != cur);
    if (mm_e && err_e < MAXC) err_e++;
    if (stage == 1) begin
      m_ref = cur; stage = 2; j_e = 0; k_e = 0;
    end else if (sz > 0) begin
      cur = mq.pop_front();
      {j_e, k_e} = cmd_for(m_ref, cur);
      stage = 1;
    end else begin
      stage = 0; j_e = 0; k_e = 0;
    end
    if (pushed) mq.push_back(s_b);
  endtask

  // One clock: capture inputs mid-cycle, advance the reference after the edge, compare all outputs.
  task automatic cyc();
    @(negedge clk);
    s_v = tgt_if.tgt_valid; s_b = tgt_if.tgt_bit; s_f = fsm_out; s_r = reset;
    @(posedge clk);
    #1;
    model_step();
    chk("j", j, j_e);
    chk("k", k, k_e);
    chk("mismatch", mismatch, mm_e);
    chk("err_cnt", err_cnt, err_e);
    chk("busy", busy, (mq.size() > 0) || (stage != 0));
    chk("tgt_ready", tgt_if.tgt_ready, mq.size() < DEPTH);
`ifndef JK_TOGGLE_EN
    chk("jk_exclusive", j & k, 1'b0);
`endif
  endtask

  task automatic push(input bit b);
    int budget;
    budget = 50;
    tgt_if.tgt_valid = 1'b1;
    tgt_if.tgt_bit   = b;
    do begin
      cyc();
      budget--;
    end while (!pushed && budget > 0);
    if (!pushed) fail_timeout("push_accept");
    tgt_if.tgt_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 300;
    tgt_if.tgt_valid = 1'b0;
    while ((mq.size() > 0 || stage != 0) && budget > 0) begin
      cyc();
      budget--;
    end
    if (budget == 0) fail_timeout("drain");
    cyc();
    cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    int budget;
    reset = 1'b1;
    stuck = 1'b0;
    tgt_if.tgt_valid = 1'b0;
    tgt_if.tgt_bit   = 1'b0;

    // Reset state
    do_reset();
    cyc();
    chk("rst_ready", tgt_if.tgt_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err_cnt, 0);

    // 1: single ON request
    push(1'b1);
    cyc();
    chk("t1_j", j, 1'b1);
    chk("t1_k", k, 1'b0);
    cyc();
    chk("t1_j_clr", j, 1'b0);
    chk("t1_fsm_on", fsm_out, 1'b1);
    drain();
    chk("t1_busy", busy, 1'b0);
    chk("t1_err", err_cnt, 0);

    // 2: back-to-back sequence
    push(1'b1); push(1'b1); push(1'b0); push(1'b0); push(1'b1);
    drain();
    chk("t2_err", err_cnt, 0);

    // 3: FSM stuck OFF, three mismatches then saturation
    do_reset();
    stuck = 1'b1;
    push(1'b1); push(1'b1); push(1'b1);
    drain();
    chk("t3_err3", err_cnt, 3);
    for (int i = 0; i < MAXC + 5; i++) push(1'b1);
    drain();
    chk("t3_sat", err_cnt, MAXC);
    stuck = 1'b0;
    do_reset();

    // 4: reset while a command is out and at least 3 bits are queued
    tgt_if.tgt_valid = 1'b1;
    budget = 40;
    do begin
      tgt_if.tgt_bit = 1'($urandom);
      cyc();
      budget--;
    end while (!(stage == 1 && mq.size() >= 3) && budget > 0);
    if (budget == 0) fail_timeout("t4_reach_drive");
    tgt_if.tgt_valid = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("t4_j", j, 1'b0);
    chk("t4_k", k, 1'b0);
    chk("t4_busy", busy, 1'b0);
    chk("t4_err", err_cnt, 0);
    cyc();
    chk("t4_no_pulse", mismatch, 1'b0);
    chk("t4_ready", tgt_if.tgt_ready, 1'b1);
    drain();

    // 5: valid held through full, 12 random bits across pointer wrap
    for (int i = 0; i < 12; i++) begin
      push(1'($urandom));
      tgt_if.tgt_valid = 1'b1;
    end
    tgt_if.tgt_valid = 1'b0;
    drain();
    chk("t5_err", err_cnt, 0);

    // 6: 1,0,0 (set/clear or toggle depending on build)
    push(1'b1); push(1'b0); push(1'b0);
    drain();
    chk("t6_err", err_cnt, 0);

    // Random traffic with occasional stuck read-back
    for (int i = 0; i < 300; i++) begin
      tgt_if.tgt_valid = 1'($urandom_range(0, 2) != 0);
      tgt_if.tgt_bit   = 1'($urandom);
      stuck            = ($urandom_range(0, 9) == 0);
      cyc();
    end
    stuck = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
